// File: rtl/keypad_pkg.sv
// Shared definitions for the matrix keypad scanner: event type codes,
// scanner FSM state encoding and a small constant helper.
package keypad_pkg;

    localparam logic [1:0] EV_PRESS   = 2'b01;
    localparam logic [1:0] EV_RELEASE = 2'b10;
    localparam logic [1:0] EV_REPEAT  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DB_PRESS,
        ST_SCAN,
        ST_PRESSED,
        ST_DB_RELEASE
    } scan_state_e;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/keypad_scanner_multi_if.sv
// Event stream between the keypad scanner (master) and its consumer (slave).
interface keypad_scanner_multi_if #(
    parameter int EV_W = 6
);
    logic            ev_valid;
    logic            ev_ready;
    logic [EV_W-1:0] ev_data;

    modport master (output ev_valid, output ev_data, input ev_ready);
    modport slave  (input ev_valid, input ev_data, output ev_ready);
endinterface

// File: rtl/key_event_fifo.sv
// First-word-fall-through event FIFO. A push into a full FIFO is dropped
// (drop_o pulses) unless a pop frees the slot in the same cycle.
module key_event_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             drop_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full || do_pop);
    assign drop_o  = push_i && full && !do_pop;
    // Gate the head word so the output reads zero while nothing is queued.
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/keypad_scanner_multi.sv
// Parametrised matrix keypad scanner: debounced press/release detection,
// single-key tracking with auto-repeat, and an event FIFO toward the CPU.
module keypad_scanner_multi
    import keypad_pkg::*;
#(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int SETTLE_CYCLES   = 3,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ROWS-1:0]       row_in,
    output logic [COLS-1:0]       col_out,
    keypad_scanner_multi_if.master ev,
    output logic                  key_held,
    output logic                  overflow
);
    localparam int RW      = $clog2(ROWS);
    localparam int CW      = $clog2(COLS);
    localparam int EV_W    = 2 + RW + CW;
    localparam int CNT_MAX = max_of(max_of(DEBOUNCE_CYCLES, SETTLE_CYCLES),
                                    max_of(REPEAT_DELAY, REPEAT_PERIOD));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_CNT  = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CW-1:0]    COL_LAST    = CW'(COLS - 1);

    scan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] rcnt_q, rcnt_d;
    logic             rep_armed_q, rep_armed_d;
    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_lat_q, row_lat_d;
    logic [CW-1:0]    col_lat_q, col_lat_d;
    logic             overflow_q;

    logic             any_low;
    logic [RW-1:0]    low_row;
    logic             push;
    logic [1:0]       push_type;
    logic             fifo_empty;
    logic             fifo_drop;
    logic [EV_W-1:0]  fifo_data;
    logic             drive_en;
    logic [CW-1:0]    drive_col;

    assign any_low = !(&row_in);

    // Lowest-index low row wins when several rows are pulled at once.
    always_comb begin
        low_row = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (!row_in[r]) begin
                low_row = RW'(r);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rcnt_q      <= '0;
            rep_armed_q <= 1'b0;
            col_q       <= '0;
            row_lat_q   <= '0;
            col_lat_q   <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rcnt_q      <= rcnt_d;
            rep_armed_q <= rep_armed_d;
            col_q       <= col_d;
            row_lat_q   <= row_lat_d;
            col_lat_q   <= col_lat_d;
            overflow_q  <= overflow_q | fifo_drop;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rcnt_d      = rcnt_q;
        rep_armed_d = rep_armed_q;
        col_d       = col_q;
        row_lat_d   = row_lat_q;
        col_lat_d   = col_lat_q;
        push        = 1'b0;
        push_type   = EV_PRESS;
        case (state_q)
            ST_IDLE: begin
                if (any_low) begin
                    state_d = ST_DB_PRESS;
                    cnt_d   = '0;
                end
            end
            ST_DB_PRESS: begin
                if (!any_low) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == DB_LAST) begin
                    state_d = ST_SCAN;
                    col_d   = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SCAN: begin
                if (cnt_q != SETTLE_CNT) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (any_low) begin
                    state_d     = ST_PRESSED;
                    row_lat_d   = low_row;
                    col_lat_d   = col_q;
                    rcnt_d      = '0;
                    rep_armed_d = 1'b0;
                    push        = 1'b1;
                    push_type   = EV_PRESS;
                end else if (col_q == COL_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    col_d = col_q + CW'(1);
                    cnt_d = '0;
                end
            end
            ST_PRESSED: begin
                if (row_in[row_lat_q]) begin
                    state_d = ST_DB_RELEASE;
                    cnt_d   = '0;
                end else if (REPEAT_DELAY != 0) begin
                    // First repeat waits the long delay, later ones the short period.
                    if (rcnt_q == (rep_armed_q ? PERIOD_LAST : DELAY_LAST)) begin
                        push        = 1'b1;
                        push_type   = EV_REPEAT;
                        rcnt_d      = '0;
                        rep_armed_d = 1'b1;
                    end else begin
                        rcnt_d = rcnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DB_RELEASE: begin
                if (!row_in[row_lat_q]) begin
                    state_d = ST_PRESSED;
                end else if (cnt_q == DB_LAST) begin
                    state_d   = ST_IDLE;
                    push      = 1'b1;
                    push_type = EV_RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // All columns are pulled low while idle so any key press shows on the rows.
    assign drive_en  = (state_q == ST_SCAN) || (state_q == ST_PRESSED) ||
                       (state_q == ST_DB_RELEASE);
    assign drive_col = (state_q == ST_SCAN) ? col_q : col_lat_q;

    for (genvar gi = 0; gi < COLS; gi++) begin : g_col
        assign col_out[gi] = drive_en && (drive_col != CW'(gi));
    end

    key_event_fifo #(
        .WIDTH (EV_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  ({push_type, row_lat_d, col_lat_d}),
        .pop_i   (ev.ev_ready),
        .data_o  (fifo_data),
        .empty_o (fifo_empty),
        .drop_o  (fifo_drop)
    );

    assign ev.ev_valid = !fifo_empty;
    assign ev.ev_data  = fifo_data;
    assign key_held    = (state_q == ST_PRESSED);
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_keypad_scanner_multi.sv
// Directed bench for keypad_scanner_multi with a behavioural 4x4 key matrix
// and a monitor that logs every accepted event with its cycle stamp.
module tb_keypad_scanner_multi;

    logic       clk;
    logic       rst;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic       key_held;
    logic       overflow;
    logic [3:0] keys [4];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [5:0] evq [$];
    int         tq  [$];

    keypad_scanner_multi_if #(.EV_W(6)) kif ();

    keypad_scanner_multi #(
        .ROWS            (4),
        .COLS            (4),
        .DEBOUNCE_CYCLES (8),
        .SETTLE_CYCLES   (2),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (5),
        .FIFO_DEPTH      (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .row_in   (row_in),
        .col_out  (col_out),
        .ev       (kif),
        .key_held (key_held),
        .overflow (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            row_in[r] = ~|(keys[r] & ~col_out);
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && kif.ev_valid && kif.ev_ready) begin
            evq.push_back(kif.ev_data);
            tq.push_back(cyc);
            $display("event %0d: data=%b at cycle %0d", evq.size() - 1, kif.ev_data, cyc);
        end
    end

    function automatic logic [5:0] ev_at(input int i);
        return (i < evq.size()) ? evq[i] : 6'bxxxxxx;
    endfunction

    function automatic int t_at(input int i);
        return (i < tq.size()) ? tq[i] : -1;
    endfunction

    task automatic tap(input int r, input int c);
        keys[r][c] = 1'b1;
        repeat (12 + 3 * c + 4) @(negedge clk);
        keys[r][c] = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (col_out !== 4'b0000) begin errors++; $display("FAIL reset_col: got %b expected 0000", col_out); end
        checks++; if (kif.ev_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", kif.ev_valid); end
        checks++; if (kif.ev_data !== 6'b0) begin errors++; $display("FAIL reset_data: got %b expected 000000", kif.ev_data); end
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL reset_held: got %b expected 0", key_held); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_press_release();
        int n0, c0, c1;
        n0 = evq.size();
        c0 = cyc;
        keys[2] = 4'b0010;
        repeat (16) @(negedge clk);
        checks++; if (ev_at(n0) !== 6'b01_10_01) begin errors++; $display("FAIL press_data: got %b expected 011001", ev_at(n0)); end
        checks++; if (t_at(n0) != c0 + 15) begin errors++; $display("FAIL press_latency: got %0d expected %0d", t_at(n0) - c0, 15); end
        checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL press_held: got %b expected 1", key_held); end
        checks++; if (col_out !== 4'b1101) begin errors++; $display("FAIL press_col: got %b expected 1101", col_out); end
        c1 = cyc;
        keys[2] = 4'b0000;
        repeat (12) @(negedge clk);
        checks++; if (ev_at(n0 + 1) !== 6'b10_10_01) begin errors++; $display("FAIL release_data: got %b expected 101001", ev_at(n0 + 1)); end
        checks++; if (t_at(n0 + 1) != c1 + 9) begin errors++; $display("FAIL release_latency: got %0d expected %0d", t_at(n0 + 1) - c1, 9); end
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL release_held: got %b expected 0", key_held); end
        checks++; if (col_out !== 4'b0000) begin errors++; $display("FAIL release_col: got %b expected 0000", col_out); end
    endtask

    task automatic test_bounce();
        int n0;
        n0 = evq.size();
        keys[1] = 4'b0100;
        repeat (5) @(negedge clk);
        keys[1] = 4'b0000;
        repeat (20) @(negedge clk);
        checks++; if (evq.size() != n0) begin errors++; $display("FAIL bounce_events: got %0d expected 0", evq.size() - n0); end
        checks++; if (col_out !== 4'b0000) begin errors++; $display("FAIL bounce_col: got %b expected 0000", col_out); end
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL bounce_held: got %b expected 0", key_held); end
    endtask

    task automatic test_repeat();
        int n0, c0;
        logic [5:0] exp_d [6];
        int         exp_t [6];
        exp_d = '{6'b01_00_00, 6'b11_00_00, 6'b11_00_00, 6'b11_00_00, 6'b11_00_00, 6'b10_00_00};
        exp_t = '{12, 32, 37, 42, 47, 59};
        n0 = evq.size();
        c0 = cyc;
        keys[0] = 4'b0001;
        repeat (50) @(negedge clk);
        keys[0] = 4'b0000;
        repeat (12) @(negedge clk);
        checks++; if (evq.size() != n0 + 6) begin errors++; $display("FAIL repeat_count: got %0d expected 6", evq.size() - n0); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (ev_at(n0 + i) !== exp_d[i] || t_at(n0 + i) != c0 + exp_t[i]) begin
                errors++;
                $display("FAIL repeat_ev%0d: got %b at +%0d expected %b at +%0d", i, ev_at(n0 + i), t_at(n0 + i) - c0, exp_d[i], exp_t[i]);
            end
        end
    endtask

    task automatic test_overflow();
        int n0;
        logic [5:0] exp_d [5];
        exp_d = '{6'b01_00_00, 6'b10_00_00, 6'b01_11_11, 6'b10_11_11, 6'b01_10_00};
        n0 = evq.size();
        kif.ev_ready = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_initial: got %b expected 0", overflow); end
        tap(0, 0);
        tap(3, 3);
        checks++; if (kif.ev_valid !== 1'b1 || kif.ev_data !== 6'b01_00_00) begin errors++; $display("FAIL full_head: got valid=%b data=%b expected 1 010000", kif.ev_valid, kif.ev_data); end
        // Fifth event lands on the same edge as a pop, so nothing is lost.
        keys[2] = 4'b0001;
        repeat (11) @(negedge clk);
        kif.ev_ready = 1'b1;
        @(negedge clk);
        kif.ev_ready = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL push_pop_full: got overflow=%b expected 0", overflow); end
        checks++; if (evq.size() != n0 + 1) begin errors++; $display("FAIL push_pop_count: got %0d expected 1", evq.size() - n0); end
        repeat (4) @(negedge clk);
        keys[2] = 4'b0000;
        repeat (12) @(negedge clk);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow); end
        checks++; if (kif.ev_data !== 6'b10_00_00) begin errors++; $display("FAIL ovf_head: got %b expected 100000", kif.ev_data); end
        kif.ev_ready = 1'b1;
        repeat (6) @(negedge clk);
        checks++; if (evq.size() != n0 + 5) begin errors++; $display("FAIL drain_count: got %0d expected 5", evq.size() - n0); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (ev_at(n0 + i) !== exp_d[i]) begin
                errors++;
                $display("FAIL drain_ev%0d: got %b expected %b", i, ev_at(n0 + i), exp_d[i]);
            end
        end
        checks++; if (kif.ev_valid !== 1'b0 || overflow !== 1'b1) begin errors++; $display("FAIL drain_end: got valid=%b overflow=%b expected 0 1", kif.ev_valid, overflow); end
    endtask

    task automatic test_multi_key();
        int n0, c0;
        n0 = evq.size();
        c0 = cyc;
        keys[1] = 4'b0001;
        keys[3] = 4'b0100;
        repeat (16) @(negedge clk);
        checks++; if (ev_at(n0) !== 6'b01_01_00 || t_at(n0) != c0 + 12) begin errors++; $display("FAIL multi_press: got %b at +%0d expected 010100 at +12", ev_at(n0), t_at(n0) - c0); end
        checks++; if (col_out !== 4'b1110 || key_held !== 1'b1) begin errors++; $display("FAIL multi_drive: got col=%b held=%b expected 1110 1", col_out, key_held); end
        keys[1] = 4'b0000;
        keys[3] = 4'b0000;
        repeat (14) @(negedge clk);
        checks++; if (evq.size() != n0 + 2) begin errors++; $display("FAIL multi_count: got %0d expected 2", evq.size() - n0); end
        checks++; if (ev_at(n0 + 1) !== 6'b10_01_00) begin errors++; $display("FAIL multi_release: got %b expected 100100", ev_at(n0 + 1)); end
    endtask

    task automatic test_reset_mid_scan();
        int n0;
        n0 = evq.size();
        keys[0] = 4'b1000;
        repeat (10) @(negedge clk);
        checks++; if (col_out !== 4'b1110) begin errors++; $display("FAIL scan_col0: got %b expected 1110", col_out); end
        rst = 1'b1;
        keys[0] = 4'b0000;
        @(negedge clk);
        checks++; if (col_out !== 4'b0000 || kif.ev_valid !== 1'b0) begin errors++; $display("FAIL midrst_out: got col=%b valid=%b expected 0000 0", col_out, kif.ev_valid); end
        checks++; if (overflow !== 1'b0 || key_held !== 1'b0) begin errors++; $display("FAIL midrst_flags: got ovf=%b held=%b expected 0 0", overflow, key_held); end
        rst = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (evq.size() != n0 || col_out !== 4'b0000) begin errors++; $display("FAIL midrst_after: got events=%0d col=%b expected 0 0000", evq.size() - n0, col_out); end
    endtask

    initial begin
        rst = 1'b1;
        kif.ev_ready = 1'b1;
        for (int r = 0; r < 4; r++) keys[r] = 4'b0000;
        test_reset();
        test_press_release();
        test_bounce();
        test_repeat();
        test_overflow();
        test_multi_key();
        test_reset_mid_scan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
